// File: rtl/scroll_engine_pkg.sv
// Shared console types for the scroll engine: row/column geometry, the scroll
// command record, FSM states and the command decode helpers.
package scroll_engine_pkg;

    localparam int CONSOLE_LINES   = 24;
    localparam int CONSOLE_COLUMNS = 80;
    localparam int ROW_W           = 5;
    localparam int ADDR_W          = 12;

    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [ROW_W:0]   ROWS_ONE = (ROW_W+1)'(1);

    typedef struct packed {
        logic             dir;     // 0 up, 1 down
        logic [ROW_W-1:0] step;
        logic [ROW_W-1:0] top;
        logic [ROW_W-1:0] bottom;
        logic             reset;
    } Scrolling_t;

    typedef enum logic [2:0] {IDLE, COPY, DRAIN, CLEAR, DONE} ScrollState_t;

    typedef struct packed {
        logic             valid;
        logic             dir;
        logic [ROW_W:0]   st;
        logic [ROW_W:0]   copy_rows;
        logic [ROW_W-1:0] top;
        logic [ROW_W-1:0] bottom;
    } scroll_plan_t;

    // Region height, effective step (0 -> 1, clamped to height) and rows to copy.
    function automatic scroll_plan_t make_plan(input Scrolling_t s, input int lines);
        scroll_plan_t   p;
        logic [ROW_W:0] h;
        h           = {1'b0, s.bottom} - {1'b0, s.top} + ROWS_ONE;
        p.valid     = (s.top <= s.bottom) && (int'(s.bottom) < lines);
        p.dir       = s.dir;
        p.top       = s.top;
        p.bottom    = s.bottom;
        p.st        = (s.step == '0) ? ROWS_ONE : {1'b0, s.step};
        if (p.st > h)
            p.st = h;
        p.copy_rows = h - p.st;
        return p;
    endfunction

    // First row of the vacated band: the bottom band for up, the top band for down.
    function automatic logic [ROW_W-1:0] clear_row(input logic dir, input logic [ROW_W-1:0] top,
                                                    input logic [ROW_W-1:0] bottom,
                                                    input logic [ROW_W:0] st);
        return dir ? top : bottom - st[ROW_W-1:0] + ROW_ONE;
    endfunction

endpackage

// File: rtl/scroll_addr_counter.sv
// Walks a band of rows (up or down), columns 0..COLS-1 within each row, and
// presents the linear cell address plus a flag on the band's final cell.
module scroll_addr_counter
    import scroll_engine_pkg::*;
#(
    parameter int COLS = CONSOLE_COLUMNS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              adv,
    input  logic              down,
    input  logic [ROW_W-1:0]  start_row,
    input  logic [ROW_W:0]    rows,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0] COL_ONE = COL_W'(1);

    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [ROW_W:0]   left;
    logic             dn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row  <= '0;
            col  <= '0;
            left <= '0;
            dn   <= 1'b0;
        end else if (load) begin
            row  <= start_row;
            col  <= '0;
            left <= rows;
            dn   <= down;
        end else if (adv) begin
            if (col == COL_MAX) begin
                col  <= '0;
                row  <= dn ? row - ROW_ONE : row + ROW_ONE;
                left <= left - ROWS_ONE;
            end else begin
                col <= col + COL_ONE;
            end
        end
    end

    assign addr = ADDR_W'(int'(row) * COLS) + ADDR_W'(col);
    assign last = (col == COL_MAX) && (left == ROWS_ONE);

endmodule

// File: rtl/scroll_engine.sv
// Character-RAM scroll engine: copies a row band by step rows, then blanks the
// vacated rows. Define SCROLL_REQ_BUFFER_EN to queue one request while busy.
module scroll_engine
    import scroll_engine_pkg::*;
#(
    parameter int LINES  = CONSOLE_LINES,
    parameter int COLS   = CONSOLE_COLUMNS,
    parameter int CELL_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scroll_req,
    input  Scrolling_t        scroll,
    input  logic [CELL_W-1:0] blank_cell,
    output logic [11:0]       rd_addr,
    input  logic [CELL_W-1:0] rd_data,
    output logic              wr_en,
    output logic [11:0]       wr_addr,
    output logic [CELL_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              dropped
);

    ScrollState_t      state, state_d;
    logic              launch;
    Scrolling_t        src_scroll;
    logic [CELL_W-1:0] src_blank;
    scroll_plan_t      plan;

    logic              cur_dir;
    logic [ROW_W:0]    cur_st;
    logic [ROW_W-1:0]  cur_top, cur_bottom;
    logic [CELL_W-1:0] blank_q;
    logic [ADDR_W-1:0] prev_dst;
    logic              wr_pend;

    logic              ld;
    logic              ld_down;
    logic [ROW_W-1:0]  ld_start;
    logic [ROW_W:0]    ld_rows;
    logic [ADDR_W-1:0] cnt_addr;
    logic              cnt_last;
    logic [ADDR_W-1:0] src_off;

`ifdef SCROLL_REQ_BUFFER_EN
    logic              pend_vld;
    Scrolling_t        pend_scroll;
    logic [CELL_W-1:0] pend_blank;
    logic              store_pend, take_pend;
`endif

    always_comb begin
        state_d    = state;
        launch     = 1'b0;
        src_scroll = scroll;
        src_blank  = blank_cell;
        dropped    = 1'b0;
`ifdef SCROLL_REQ_BUFFER_EN
        store_pend = 1'b0;
        take_pend  = 1'b0;
`endif
        case (state)
            IDLE:    launch = scroll_req;
            COPY:    if (cnt_last) state_d = DRAIN;
            DRAIN:   state_d = CLEAR;
            CLEAR:   if (cnt_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef SCROLL_REQ_BUFFER_EN
        // A request arriving in DONE starts straight away, as if it had been buffered.
        if (state == DONE) begin
            if (pend_vld) begin
                launch     = 1'b1;
                take_pend  = 1'b1;
                src_scroll = pend_scroll;
                src_blank  = pend_blank;
                dropped    = scroll_req;
            end else begin
                launch = scroll_req;
            end
        end else if (state != IDLE && scroll_req) begin
            if (pend_vld)
                dropped = 1'b1;
            else
                store_pend = 1'b1;
        end
`else
        dropped = scroll_req && (state != IDLE);
`endif
        plan = make_plan(src_scroll, LINES);
        if (launch)
            state_d = !plan.valid ? DONE : (plan.copy_rows != '0) ? COPY : CLEAR;
        if (scroll.reset) begin
            state_d = IDLE;
            launch  = 1'b0;
`ifdef SCROLL_REQ_BUFFER_EN
            store_pend = 1'b0;
`endif
        end
    end

    // Counter loads the copy band at launch, or the clear band (at launch when
    // nothing is copied, otherwise during DRAIN).
    always_comb begin
        ld = launch || (state == DRAIN);
        if (launch && plan.copy_rows != '0) begin
            ld_start = plan.dir ? plan.bottom : plan.top;
            ld_rows  = plan.copy_rows;
            ld_down  = plan.dir;
        end else if (launch) begin
            ld_start = clear_row(plan.dir, plan.top, plan.bottom, plan.st);
            ld_rows  = plan.st;
            ld_down  = 1'b0;
        end else begin
            ld_start = clear_row(cur_dir, cur_top, cur_bottom, cur_st);
            ld_rows  = cur_st;
            ld_down  = 1'b0;
        end
    end

    scroll_addr_counter #(.COLS(COLS)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .load      (ld),
        .adv       ((state == COPY) || (state == CLEAR)),
        .down      (ld_down),
        .start_row (ld_start),
        .rows      (ld_rows),
        .addr      (cnt_addr),
        .last      (cnt_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cur_dir    <= 1'b0;
            cur_st     <= '0;
            cur_top    <= '0;
            cur_bottom <= '0;
            blank_q    <= '0;
            prev_dst   <= '0;
            wr_pend    <= 1'b0;
        end else begin
            state   <= state_d;
            wr_pend <= (state == COPY);
            if (state == COPY)
                prev_dst <= cnt_addr;
            if (launch) begin
                cur_dir    <= plan.dir;
                cur_st     <= plan.st;
                cur_top    <= plan.top;
                cur_bottom <= plan.bottom;
                blank_q    <= src_blank;
            end
        end
    end

`ifdef SCROLL_REQ_BUFFER_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_vld    <= 1'b0;
            pend_scroll <= '0;
            pend_blank  <= '0;
        end else if (scroll.reset || take_pend) begin
            pend_vld <= 1'b0;
        end else if (store_pend) begin
            pend_vld    <= 1'b1;
            pend_scroll <= scroll;
            pend_blank  <= blank_cell;
        end
    end
`endif

    // Source row sits step rows below (up) or above (down) the destination.
    assign src_off = ADDR_W'(int'(cur_st) * COLS);

    always_comb begin
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        case (state)
            COPY: begin
                rd_addr = cur_dir ? cnt_addr - src_off : cnt_addr + src_off;
                if (wr_pend) begin
                    wr_en   = 1'b1;
                    wr_addr = prev_dst;
                    wr_data = rd_data;
                end
            end
            DRAIN: begin
                wr_en   = 1'b1;
                wr_addr = prev_dst;
                wr_data = rd_data;
            end
            CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = cnt_addr;
                wr_data = blank_q;
            end
            default: ;
        endcase
    end

    assign busy = (state == COPY) || (state == DRAIN) || (state == CLEAR);
    assign done = (state == DONE);

endmodule

// File: tb/tb_scroll_engine.sv
// Randomized scoreboard bench for scroll_engine against a behavioural RAM-image model.
module tb_scroll_engine;
    import scroll_engine_pkg::*;

    localparam int LINES = 24;
    localparam int COLS  = 80;
    localparam int CELLS = LINES * COLS;
`ifdef SCROLL_REQ_BUFFER_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scroll_req = 1'b0;
    Scrolling_t  scroll = '0;
    logic [15:0] blank_cell = '0;
    logic [11:0] rd_addr, wr_addr;
    logic [15:0] rd_data, wr_data;
    logic        wr_en, busy, done, dropped;

    always #5 clk = ~clk;

    scroll_engine #(.LINES(LINES), .COLS(COLS), .CELL_W(16)) dut (
        .clk(clk), .rst(rst), .scroll_req(scroll_req), .scroll(scroll),
        .blank_cell(blank_cell), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .dropped(dropped)
    );

    // Character RAM: one-cycle read latency, not touched by rst.
    logic [15:0] mem [4096];
    logic        fill = 1'b0;
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 16'($urandom);
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

    int compared = 0, mismatched = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    typedef struct { int slot; int busy; } exp_t;
    exp_t        sbq[$];
    logic [15:0] cur_img [CELLS];
    logic [15:0] exp_img [4][CELLS];
    int          slot_wr = 0;

    // Expected screen after a scroll: each row of the region takes the row step
    // away in the scroll direction, or the blank if that row is outside the region.
    task automatic model_push(input logic d, input int st, input int tp, input int bt,
                              input logic [15:0] blk);
        logic [15:0] nxt [CELLS];
        int   h, s, n;
        exp_t e;
        for (int i = 0; i < CELLS; i++) nxt[i] = cur_img[i];
        e.busy = 0;
        if (tp <= bt && bt < LINES) begin
            h = bt - tp + 1;
            s = (st == 0) ? 1 : st;
            if (s > h) s = h;
            for (int r = tp; r <= bt; r++)
                for (int c = 0; c < COLS; c++)
                    if (!d) nxt[r*COLS+c] = (r + s <= bt) ? cur_img[(r+s)*COLS+c] : blk;
                    else    nxt[r*COLS+c] = (r - s >= tp) ? cur_img[(r-s)*COLS+c] : blk;
            n = (h - s) * COLS;
            e.busy = n + ((n > 0) ? 1 : 0) + s * COLS;
        end
        for (int i = 0; i < CELLS; i++) begin
            cur_img[i] = nxt[i];
            exp_img[slot_wr][i] = nxt[i];
        end
        e.slot  = slot_wr;
        slot_wr = (slot_wr + 1) % 4;
        sbq.push_back(e);
    endtask

    task automatic issue(input logic d, input int st, input int tp, input int bt,
                         input logic [15:0] blk, input bit run);
        @(posedge clk); #1;
        scroll.dir    = d;
        scroll.step   = ROW_W'(st);
        scroll.top    = ROW_W'(tp);
        scroll.bottom = ROW_W'(bt);
        scroll.reset  = 1'b0;
        blank_cell    = blk;
        scroll_req    = 1'b1;
        if (run) model_push(d, st, tp, bt, blk);
        @(posedge clk); #1;
        scroll_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sbq.size() != 0 || busy || done) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 6000) begin
            compared++;
            mismatched++;
            $display("FAIL idle_timeout: still busy after %0d cycles, want done within 6000", n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic resync();
        @(negedge clk);
        for (int i = 0; i < CELLS; i++) cur_img[i] = mem[i];
    endtask

    int bcnt = 0, drops = 0, stray = 0;

    initial begin : monitor
        exp_t e;
        int   diff;
        forever begin
            @(negedge clk);
            if (rst) begin
                bcnt = 0;
            end else begin
                if (dropped) drops++;
                if (wr_en && !busy) stray++;
                if (busy) bcnt++;
                if (done) begin
                    if (sbq.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_done: got done=1 want 0 (no scroll outstanding)");
                    end else begin
                        e = sbq.pop_front();
                        chk("busy_cycles", 64'(bcnt), 64'(e.busy));
                        diff = 0;
                        for (int i = 0; i < CELLS; i++)
                            if (mem[i] !== exp_img[e.slot][i]) diff++;
                        chk("ram_cells_wrong", 64'(diff), 64'(0));
                        chk("busy_during_done", 64'(busy), 64'(0));
                    end
                    bcnt = 0;
                end else if (!busy) begin
                    bcnt = 0;
                end
            end
        end
    end

    initial begin
        int d0, tp, bt;
        rst  = 1'b1;
        fill = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("reset_outputs", 64'({busy, done, dropped, wr_en, rd_addr, wr_addr, wr_data}), 64'(0));
        fill = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        resync();
        chk("idle_outputs", 64'({busy, done, dropped, wr_en, rd_addr, wr_addr, wr_data}), 64'(0));

        issue(1'b0, 1, 0, 23, 16'hA5A5, 1'b1); wait_idle();   // full screen up by one
        issue(1'b1, 2, 5, 10, 16'h0F0F, 1'b1); wait_idle();   // partial region down by two
        issue(1'b0, 9, 2, 4,  16'h1234, 1'b1); wait_idle();   // step beyond height
        issue(1'b0, 1, 10, 3, 16'hDEAD, 1'b1); wait_idle();   // top > bottom
        issue(1'b1, 3, 0, 30, 16'hBEEF, 1'b1); wait_idle();   // bottom off screen
        issue(1'b1, 0, 7, 7,  16'h7777, 1'b1); wait_idle();   // step 0 on single row

        for (int k = 0; k < 8; k++) begin
            tp = $urandom_range(0, 23);
            bt = (k % 3 == 2) ? $urandom_range(0, 25) : $urandom_range(tp, 23);
            issue(1'($urandom_range(0, 1)), $urandom_range(0, 8), tp, bt, 16'($urandom), 1'b1);
            wait_idle();
        end

        // Requests while busy: buffered one runs, the rest are dropped.
        d0 = drops;
        issue(1'b0, 3, 0, 23, 16'h1111, 1'b1);
        repeat (50) @(posedge clk);
        issue(1'b1, 1, 4, 20, 16'h2222, BUF_EN);
        repeat (5) @(posedge clk);
        issue(1'b0, 2, 3, 9, 16'h3333, 1'b0);
        wait_idle();
        chk("dropped_pulses", 64'(drops - d0), 64'(BUF_EN ? 1 : 2));

        // scroll.reset abort around busy cycle 100, with a queued request discarded.
        issue(1'b0, 1, 0, 23, 16'h4444, 1'b0);
        repeat (50) @(posedge clk);
        issue(1'b1, 1, 0, 23, 16'h4545, 1'b0);
        repeat (46) @(posedge clk); #1;
        scroll.reset = 1'b1;
        @(posedge clk); #1;
        scroll.reset = 1'b0;
        @(negedge clk);
        chk("abort_outputs", 64'({busy, done, wr_en, rd_addr, wr_addr, wr_data}), 64'(0));
        repeat (2100) @(negedge clk);
        chk("abort_stays_idle", 64'({busy, done}), 64'(0));
        resync();

        // rst abort around busy cycle 100.
        issue(1'b1, 1, 0, 23, 16'h5555, 1'b0);
        repeat (98) @(posedge clk); #1;
        rst = 1'b1;
        #2;
        chk("rst_abort_outputs", 64'({busy, done, dropped, wr_en, rd_addr, wr_addr, wr_data}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_abort_idle", 64'({busy, done, wr_en}), 64'(0));
        resync();

        issue(1'b0, 2, 1, 22, 16'h6666, 1'b1);
        wait_idle();
        chk("stray_writes", 64'(stray), 64'(0));
        chk("scoreboard_empty", 64'(sbq.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/scroll_engine.md
SCROLL_ENGINE -- requirements
Module: scroll_engine

Interface
REQ-001 SHALL have parameter LINES, default 24, meaning text rows in the character RAM.
REQ-002 SHALL have parameter COLS, default 80, meaning cells per row.
REQ-003 SHALL have parameter CELL_W, default 16, meaning bits per cell (char + attribute).
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port scroll_req  input  1  single-cycle request pulse (upstream scrollReady).
REQ-007 SHALL have port scroll  input  Scrolling_t  dir (0 up, 1 down), step, top, bottom, reset.
REQ-008 SHALL have port blank_cell  input  CELL_W  fill value for vacated rows, sampled with scroll_req.
REQ-009 SHALL have port rd_addr  output  12  character RAM read address, row*COLS+col.
REQ-010 SHALL have port rd_data  input  CELL_W  read data, valid one cycle after rd_addr.
REQ-011 SHALL have ports wr_en  output  1, wr_addr  output  12, wr_data  output  CELL_W  RAM write port.
REQ-012 SHALL have ports busy  output  1, done  output  1 (one-cycle pulse), dropped  output  1 (one-cycle pulse).

Function
REQ-013 SHALL use states IDLE, COPY, DRAIN, CLEAR, DONE; scroll_req in IDLE latches scroll and blank_cell and enters COPY next cycle.
REQ-014 SHALL compute height H=bottom-top+1; step 0 treated as 1; step>H clamped to H (copy count zero, whole region cleared).
REQ-015 SHALL treat top>bottom or bottom>=LINES as invalid: no writes, straight to DONE.
REQ-016 Up: SHALL copy row r+step to row r for r=top..bottom-step ascending, then clear rows bottom-step+1..bottom.
REQ-017 Down: SHALL copy row r-step to row r for r=bottom..top+step descending, then clear rows top..top+step-1.
REQ-018 Within a row SHALL traverse columns 0..COLS-1 ascending.
REQ-019 COPY SHALL issue one read per cycle; the write for read k SHALL occur in the cycle read k+1 issues; DRAIN writes the final copied cell.
REQ-020 CLEAR SHALL write blank_cell to one cell per cycle; with zero copy cells COPY/DRAIN are skipped.
REQ-021 Total busy cycles SHALL be N+1+C where N=(H-step)*COLS copy cells (the +1 omitted when N=0), C=step*COLS.
REQ-022 DONE SHALL assert done for exactly one cycle with busy low, then return to IDLE.
REQ-023 busy SHALL be high in COPY, DRAIN and CLEAR only; wr_en low outside writing cycles.
REQ-024 scroll.reset high in any state SHALL abort next edge to IDLE, no done, pending request discarded.
REQ-025 scroll_req while busy SHALL be handled per REQ-028/029; scroll_req coincident with DONE counts as busy.

Reset
REQ-026 rst SHALL force IDLE; busy, done, dropped, wr_en 0; rd_addr, wr_addr, wr_data 0; pending buffer empty.
REQ-027 rst mid-operation SHALL abandon it without completing writes; the RAM keeps partially scrolled contents.

Configuration
REQ-028 With SCROLL_REQ_BUFFER_EN defined, one pending request (scroll + blank_cell) SHALL be stored when busy; it starts in the cycle after DONE; a second while pending SHALL pulse dropped.
REQ-029 Without SCROLL_REQ_BUFFER_EN, any scroll_req while not IDLE SHALL be ignored and pulse dropped.

Structure
REQ-030 Scrolling_t, CONSOLE_LINES, CONSOLE_COLUMNS and the ScrollState_t enum SHALL live in the shared package/header.
REQ-031 Row/column traversal SHALL be one sub-module scroll_addr_counter (start row, direction, count; emits addr, last).

Verification
REQ-032 Up, top=0 bottom=23 step=1: row k gets old row k+1 (k=0..22), row 23 all blank_cell; busy 1921 cycles, one done.
REQ-033 Down, top=5 bottom=10 step=2: rows 7..10 get old rows 5..8, rows 5..6 blank, rows 0..4 and 11..23 unchanged.
REQ-034 Up, top=2 bottom=4 step=9: no reads, rows 2..4 blank; busy 240 cycles.
REQ-035 top=10 bottom=3: no wr_en, done one cycle after entering DONE, RAM unchanged.
REQ-036 scroll_req during busy: with SCROLL_REQ_BUFFER_EN, two scrolls completed back-to-back; without, dropped pulses, one scroll.
REQ-037 scroll.reset at busy cycle 100 and rst at busy cycle 100: both reach IDLE, no done, outputs at reset values.
